program_loader: RTL and testbench

Boot-time instruction-memory writer for the 8-bit pipelined processor. Accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words and writes them to consecutive instruction-memory addresses from 0. This is the write port the fetch stage's read-only instruction path lacks. Holds the processor in reset until a complete, well-formed image has been written, then releases it.

---
 rtl/program_loader.sv | 179 +++++++++++++++++
 tb/tb_program_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: boot-time instruction-memory writer.
// Takes a byte stream (length header followed by MSB-first 16-bit words),
// writes the words to consecutive addresses from 0, and holds the CPU in
// reset until the whole image has been written.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte that must match the XOR of all word bytes.
module program_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [7:0]            iByte,
  input  logic                  iByteValid,
  output logic                  oByteReady,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oWriteData,
  output logic                  oCpuReset,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oError
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_WORD_HI,
    S_WORD_LO,
    S_WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
  logic [1:0]            lenHi_q, lenHi_d;
  logic [7:0]            hiByte_q, hiByte_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  accept;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            checksum_q, checksum_d;
`endif

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    lenHi_d       = lenHi_q;
    hiByte_d      = hiByte_q;
    data_d        = data_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    checksum_d    = checksum_q;
`endif
    oByteReady    = 1'b0;
    oWriteEnable  = 1'b0;
    oBusy         = 1'b1;
    oDone         = 1'b0;
    oError        = 1'b0;
    oCpuReset     = 1'b1;

    case (state_q)
      S_LEN_HI, S_LEN_LO, S_WORD_HI, S_WORD_LO: oByteReady = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK:                                  oByteReady = 1'b1;
`endif
      default:                                  oByteReady = 1'b0;
    endcase
    accept = iByteValid && oByteReady;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        oBusy     = 1'b0;
        oDone     = (state_q == S_DONE);
        oError    = (state_q == S_ERROR);
        oCpuReset = (state_q != S_DONE);
        if (iStart) begin
          state_d = S_LEN_HI;
          addr_d  = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          checksum_d = 8'h00;
`endif
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          if (iByte[7:2] != 6'd0) begin
            state_d = S_ERROR;
          end else begin
            lenHi_d = iByte[1:0];
            state_d = S_LEN_LO;
          end
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          remaining_d = ADDR_WIDTH'({lenHi_q, iByte});
          state_d     = S_WORD_HI;
        end
      end
      S_WORD_HI: begin
        if (accept) begin
          hiByte_d = iByte;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          checksum_d = checksum_q ^ iByte;
`endif
          state_d  = S_WORD_LO;
        end
      end
      S_WORD_LO: begin
        if (accept) begin
          data_d  = DATA_WIDTH'({hiByte_q, iByte});
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          checksum_d = checksum_q ^ iByte;
`endif
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        oWriteEnable = 1'b1;
        if (remaining_q == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          state_d     = S_WORD_HI;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          state_d = (iByte == checksum_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      lenHi_q     <= 2'd0;
      hiByte_q    <= 8'h00;
      data_q      <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      checksum_q  <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      lenHi_q     <= lenHi_d;
      hiByte_q    <= hiByte_d;
      data_q      <= data_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  assign oWriteAddress = addr_q;
  assign oWriteData    = data_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader. Honours PROGRAM_LOADER_CHECKSUM_EN
// by appending a checksum byte to every frame when the macro is defined.
module tb_program_loader;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iStart = 1'b0;
  logic [7:0]  iByte = 8'h00;
  logic        iByteValid = 1'b0;
  logic        oByteReady;
  logic        oWriteEnable;
  logic [9:0]  oWriteAddress;
  logic [15:0] oWriteData;
  logic        oCpuReset;
  logic        oBusy;
  logic        oDone;
  logic        oError;

  int compareCount = 0;
  int failCount = 0;

  int          wrCount = 0;
  int          lowCount = 0;
  logic [9:0]  wrAddr [2048];
  logic [15:0] wrData [2048];
  logic [15:0] frameWords [1024];

  program_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iByte(iByte),
    .iByteValid(iByteValid), .oByteReady(oByteReady),
    .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress),
    .oWriteData(oWriteData), .oCpuReset(oCpuReset), .oBusy(oBusy),
    .oDone(oDone), .oError(oError)
  );

  // 10 ns clock
  always #5 Clock = ~Clock;

  // Record every write strobe and count busy cycles with ready low.
  initial begin
    forever begin
      @(negedge Clock);
      if (oWriteEnable) begin
        if (wrCount < 2048) begin
          wrAddr[wrCount] = oWriteAddress;
          wrData[wrCount] = oWriteData;
        end
        wrCount = wrCount + 1;
      end
      if (oBusy && !oByteReady) lowCount = lowCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount = compareCount + 1;
    if (got !== exp) begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearCounts();
    wrCount  = 0;
    lowCount = 0;
  endtask

  task automatic pulseStart();
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
  endtask

  // Present one byte after an optional idle gap; returns at the negedge after acceptance.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int waitCycles;
    iByteValid = 1'b0;
    repeat (gap) @(negedge Clock);
    iByte      = b;
    iByteValid = 1'b1;
    waitCycles = 0;
    while (!oByteReady && waitCycles < 100) begin
      @(negedge Clock);
      waitCycles++;
    end
    if (waitCycles >= 100) checkOutput("readyTimeout", 32'(waitCycles), 32'd0);
    @(negedge Clock);
    iByteValid = 1'b0;
  endtask

  // Send a full frame of nWords from frameWords, with optional random gaps.
  task automatic applyStimulus(input int nWords, input int maxGap, input bit badSum);
    logic [9:0] n;
    logic [7:0] sum;
    n   = 10'(nWords - 1);
    sum = 8'h00;
    sendByte({6'd0, n[9:8]}, 0);
    sendByte(n[7:0], 0);
    for (int i = 0; i < nWords; i++) begin
      sendByte(frameWords[i][15:8], $urandom_range(0, maxGap));
      sendByte(frameWords[i][7:0], $urandom_range(0, maxGap));
      sum = sum ^ frameWords[i][15:8] ^ frameWords[i][7:0];
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sendByte(badSum ? (sum ^ 8'h5A) : sum, 0);
`else
    if (badSum) sum = ~sum;
`endif
  endtask

  task automatic waitEnd();
    int n;
    n = 0;
    while (!(oDone || oError) && n < 50) begin
      @(negedge Clock);
      n++;
    end
    checkOutput("endReached", 32'(n < 50), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cpuReset"}, 32'(oCpuReset), 32'd1);
    checkOutput({tag, "_we"},       32'(oWriteEnable), 32'd0);
    checkOutput({tag, "_addr"},     32'(oWriteAddress), 32'd0);
    checkOutput({tag, "_data"},     32'(oWriteData), 32'd0);
    checkOutput({tag, "_ready"},    32'(oByteReady), 32'd0);
    checkOutput({tag, "_busy"},     32'(oBusy), 32'd0);
    checkOutput({tag, "_done"},     32'(oDone), 32'd0);
    checkOutput({tag, "_error"},    32'(oError), 32'd0);
  endtask

  initial begin
    int errs;

    // Reset state
    repeat (3) @(negedge Clock);
    checkResetOutputs("reset");
    Reset = 1'b0;
    @(negedge Clock);

    // Basic two-word frame
    clearCounts();
    pulseStart();
    sendByte(8'h00, 0);
    sendByte(8'h01, 0);
    sendByte(8'h12, 0);
    sendByte(8'h34, 0);
    checkOutput("latencyWe",   32'(oWriteEnable), 32'd1);
    checkOutput("latencyAddr", 32'(oWriteAddress), 32'd0);
    checkOutput("latencyData", 32'(oWriteData), 32'h1234);
    checkOutput("writeReady",  32'(oByteReady), 32'd0);
    sendByte(8'hAB, 0);
    sendByte(8'hCD, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sendByte(8'h40, 0);
`endif
    waitEnd();
    checkOutput("basicCount", 32'(wrCount), 32'd2);
    checkOutput("basicAddr0", 32'(wrAddr[0]), 32'd0);
    checkOutput("basicData0", 32'(wrData[0]), 32'h1234);
    checkOutput("basicAddr1", 32'(wrAddr[1]), 32'd1);
    checkOutput("basicData1", 32'(wrData[1]), 32'hABCD);
    checkOutput("basicDone",  32'(oDone), 32'd1);
    checkOutput("basicCpuRst", 32'(oCpuReset), 32'd0);
    checkOutput("basicError", 32'(oError), 32'd0);

    // Bad length header
    clearCounts();
    pulseStart();
    sendByte(8'h04, 0);
    checkOutput("lenErr",       32'(oError), 32'd1);
    checkOutput("lenErrCpuRst", 32'(oCpuReset), 32'd1);
    checkOutput("lenErrDone",   32'(oDone), 32'd0);
    checkOutput("lenErrBusy",   32'(oBusy), 32'd0);
    @(negedge Clock);
    checkOutput("lenErrWrites", 32'(wrCount), 32'd0);

    // Full 1024-word image
    for (int i = 0; i < 1024; i++) frameWords[i] = 16'(i * 7 + 3);
    clearCounts();
    pulseStart();
    applyStimulus(1024, 0, 1'b0);
    waitEnd();
    checkOutput("bigCount",    32'(wrCount), 32'd1024);
    checkOutput("bigLastAddr", 32'(wrAddr[1023]), 32'd1023);
    checkOutput("bigLastData", 32'(wrData[1023]), 32'(16'(1023 * 7 + 3)));
    errs = 0;
    for (int i = 0; i < 1024; i++)
      if (wrAddr[i] !== 10'(i) || wrData[i] !== frameWords[i]) errs++;
    checkOutput("bigContent", 32'(errs), 32'd0);
    checkOutput("bigDone",    32'(oDone), 32'd1);

    // Three-word frame with random valid gaps
    frameWords[0] = 16'hDEAD;
    frameWords[1] = 16'hBEEF;
    frameWords[2] = 16'h0F0F;
    clearCounts();
    pulseStart();
    applyStimulus(3, 3, 1'b0);
    waitEnd();
    checkOutput("gapCount", 32'(wrCount), 32'd3);
    checkOutput("gapData0", 32'({22'd0, wrAddr[0]} << 16 | wrData[0]), 32'h0000DEAD);
    checkOutput("gapData1", 32'({22'd0, wrAddr[1]} << 16 | wrData[1]), 32'h0001BEEF);
    checkOutput("gapData2", 32'({22'd0, wrAddr[2]} << 16 | wrData[2]), 32'h00020F0F);
    checkOutput("gapReadyLow", 32'(lowCount), 32'd3);
    checkOutput("gapDone", 32'(oDone), 32'd1);

    // Reset after two of four words, then reload
    frameWords[0] = 16'h1111;
    frameWords[1] = 16'h2222;
    frameWords[2] = 16'h3333;
    frameWords[3] = 16'h4444;
    clearCounts();
    pulseStart();
    sendByte(8'h00, 0);
    sendByte(8'h03, 0);
    sendByte(8'h11, 0);
    sendByte(8'h11, 0);
    sendByte(8'h22, 0);
    sendByte(8'h22, 0);
    checkOutput("midAddrBefore", 32'(oWriteAddress), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    checkResetOutputs("midReset");
    checkOutput("midWrites", 32'(wrCount), 32'd2);
    Reset = 1'b0;
    @(negedge Clock);
    clearCounts();
    pulseStart();
    applyStimulus(4, 0, 1'b0);
    waitEnd();
    checkOutput("reloadCount", 32'(wrCount), 32'd4);
    errs = 0;
    for (int i = 0; i < 4; i++)
      if (wrAddr[i] !== 10'(i) || wrData[i] !== frameWords[i]) errs++;
    checkOutput("reloadContent", 32'(errs), 32'd0);
    checkOutput("reloadDone", 32'(oDone), 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Wrong then correct checksum on the same frame
    frameWords[0] = 16'h1234;
    frameWords[1] = 16'hABCD;
    clearCounts();
    pulseStart();
    applyStimulus(2, 0, 1'b1);
    waitEnd();
    checkOutput("badSumError", 32'(oError), 32'd1);
    checkOutput("badSumCpuRst", 32'(oCpuReset), 32'd1);
    clearCounts();
    pulseStart();
    applyStimulus(2, 0, 1'b0);
    waitEnd();
    checkOutput("goodSumDone", 32'(oDone), 32'd1);
    checkOutput("goodSumCount", 32'(wrCount), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
